// File: rtl/div5_pkg.sv
// Shared definitions for the divisible-by-5 serial framer: word width,
// remainder state encoding and the mod-5 remainder transition table.
package div5_pkg;

    localparam int WORD_W = 4;

    typedef enum logic [2:0] {
        REM0 = 3'd0,
        REM1 = 3'd1,
        REM2 = 3'd2,
        REM3 = 3'd3,
        REM4 = 3'd4
    } rem_e;

    // Next remainder after shifting one bit in: (2*r + b) mod 5.
    function automatic rem_e rem_next(input rem_e r, input logic b);
        rem_e n;
        case (r)
            REM0:    n = b ? REM1 : REM0;
            REM1:    n = b ? REM3 : REM2;
            REM2:    n = b ? REM0 : REM4;
            REM3:    n = b ? REM2 : REM1;
            REM4:    n = b ? REM4 : REM3;
            default: n = REM0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/div5_rem_fsm.sv
// Running mod-5 remainder of an MSB-first bit stream, with a registered
// "divisible" flag; restart_i treats the prior remainder as zero.
module div5_rem_fsm (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       adv_i,
    input  logic       restart_i,
    input  logic       bit_i,
    output logic [2:0] rem_o,
    output logic       div5_o
);
    import div5_pkg::*;

    rem_e remState_q, remState_d, remBase;
    logic div5_q, div5_d;

    always_comb begin
        remBase    = restart_i ? REM0 : remState_q;
        remState_d = remState_q;
        div5_d     = div5_q;
        // Any advance means at least one bit is in the frame, so the flag is just rem == 0.
        if (adv_i) begin
            remState_d = rem_next(remBase, bit_i);
            div5_d     = (remState_d == REM0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            remState_q <= REM0;
            div5_q     <= 1'b0;
        end else begin
            remState_q <= remState_d;
            div5_q     <= div5_d;
        end
    end

    assign rem_o  = remState_q;
    assign div5_o = div5_q;

endmodule

// File: rtl/div5_serial_framer.sv
// Packs an MSB-first serial stream into 4-bit words behind a valid/ready
// register and tracks the frame remainder mod 5. Optional: DIV5_FRAMER_DROP_CNT_EN.
module div5_serial_framer #(
    parameter int WORD_W = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    input  logic              frame_start_i,
    output logic              bit_ready_o,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    input  logic              word_ready_i,
`ifdef DIV5_FRAMER_DROP_CNT_EN
    output logic [7:0]        drop_cnt_o,
`endif
    output logic [2:0]        rem_o,
    output logic              frame_div5_o
);
    import div5_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] shReg_q, shReg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wordValid_q, wordValid_d;
    logic              accept, restart, complete;

    // Only the word-completing bit has to wait for a stalled output register.
    assign bit_ready_o = !((cnt_q == LAST) && wordValid_q && !word_ready_i);
    assign accept      = bit_valid_i && bit_ready_o;
    assign restart     = accept && frame_start_i;
    assign complete    = accept && !frame_start_i && (cnt_q == LAST);

    always_comb begin
        shReg_d     = shReg_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wordValid_d = wordValid_q;
        if (accept) begin
            if (frame_start_i) begin
                shReg_d = {{(WORD_W-1){1'b0}}, bit_i};
                cnt_d   = CNT_W'(1);
            end else begin
                shReg_d = {shReg_q[WORD_W-2:0], bit_i};
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
        if (complete) begin
            word_d      = {shReg_q[WORD_W-2:0], bit_i};
            wordValid_d = 1'b1;
        end else if (wordValid_q && word_ready_i) begin
            wordValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shReg_q     <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            wordValid_q <= 1'b0;
        end else begin
            shReg_q     <= shReg_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wordValid_q <= wordValid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = wordValid_q;

`ifdef DIV5_FRAMER_DROP_CNT_EN
    logic [7:0] dropCnt_q, dropCnt_d;
    logic [8:0] dropSum;

    assign dropSum = {1'b0, dropCnt_q} + 9'(cnt_q);

    always_comb begin
        dropCnt_d = dropCnt_q;
        if (restart) begin
            dropCnt_d = dropSum[8] ? 8'hFF : dropSum[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dropCnt_q <= '0;
        else         dropCnt_q <= dropCnt_d;
    end

    assign drop_cnt_o = dropCnt_q;
`endif

    div5_rem_fsm u_rem_fsm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .adv_i     (accept),
        .restart_i (restart),
        .bit_i     (bit_i),
        .rem_o     (rem_o),
        .div5_o    (frame_div5_o)
    );

endmodule
